// File: rtl/vita49_pkg.sv
// Shared state encoding, VITA-49 header field positions and TSTRB codes for the packet arbiter.
package vita49_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } arb_state_e;

  localparam int PKT_SIZE_LSB = 0;
  localparam int PKT_SIZE_MSB = 15;

  localparam logic [7:0] STRB_FULL = 8'hff;
  localparam logic [7:0] STRB_HALF = 8'h0f;

endpackage

// File: rtl/vita49_rr_select.sv
// Round-robin pick: first requester searching upward from (last_i+1) mod NUM_SRC, with wrap.
// Purely combinational, zero latency; no backpressure of its own.
module vita49_rr_select
  import vita49_pkg::*;
#(
  parameter int NUM_SRC = 2
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [1:0]         last_i,
  output logic [1:0]         idx_o,
  output logic               vld_o
);

  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        if (!vld_o && req_i[j] && (((int'(last_i) + i) % NUM_SRC) == j)) begin
          vld_o = 1'b1;
          idx_o = 2'(j);
        end
      end
    end
  end

endmodule

// File: rtl/vita49_pkt_arbiter.sv
// Packet-level round-robin merge of NUM_SRC VITA-49 streams; zero-latency pass-through, one bubble per packet.
// Downstream TREADY is routed only to the granted source. VITA49_ARB_STATS_EN adds per-source packet counters.
module vita49_pkt_arbiter
  import vita49_pkg::*;
#(
  parameter int          NUM_SRC  = 2,
  parameter logic [15:0] MAX_SIZE = 16'd4096
) (
  input  logic                    AXIS_ACLK,
  input  logic                    AXIS_ARESET,
  input  logic [64*NUM_SRC-1:0]   S_AXIS_TDATA,
  input  logic [NUM_SRC-1:0]      S_AXIS_TVALID,
  output logic [NUM_SRC-1:0]      S_AXIS_TREADY,
  output logic [63:0]             M_AXIS_TDATA,
  output logic                    M_AXIS_TVALID,
  input  logic                    M_AXIS_TREADY,
  output logic                    M_AXIS_TLAST,
  output logic [7:0]              M_AXIS_TSTRB,
  output logic [1:0]              M_AXIS_TDEST,
  input  logic                    enable,
  output logic [15:0]             size_err_cnt
`ifdef VITA49_ARB_STATS_EN
  ,
  output logic [16*NUM_SRC-1:0]   pkt_cnt
`endif
);

  arb_state_e  state_q;
  logic [1:0]  grant_q;
  logic [1:0]  last_grant_q;
  logic [15:0] beats_left_q;
  logic        odd_q;
  logic [15:0] err_cnt_q;
  logic [15:0] err_cnt_d;

  logic        active;
  logic        xfer;
  logic        sel_vld;
  logic [1:0]  sel_idx;
  logic [63:0] g_dat;
  logic        g_vld;
  logic [15:0] pkt_size;
  logic [15:0] hdr_beats_left;
  logic        hdr_err;

  vita49_rr_select #(.NUM_SRC(NUM_SRC)) u_rr (
    .req_i  (S_AXIS_TVALID),
    .last_i (last_grant_q),
    .idx_o  (sel_idx),
    .vld_o  (sel_vld)
  );

  always_comb begin
    g_dat         = '0;
    g_vld         = 1'b0;
    S_AXIS_TREADY = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == 2'(i)) begin
        g_dat            = S_AXIS_TDATA[64*i +: 64];
        g_vld            = S_AXIS_TVALID[i];
        S_AXIS_TREADY[i] = active && M_AXIS_TREADY;
      end
    end
  end

  assign active         = (state_q != IDLE);
  assign M_AXIS_TDATA   = g_dat;
  assign M_AXIS_TVALID  = active && g_vld;
  assign M_AXIS_TDEST   = grant_q;
  assign xfer           = M_AXIS_TVALID && M_AXIS_TREADY;
  assign pkt_size       = g_dat[PKT_SIZE_MSB:PKT_SIZE_LSB];
  assign hdr_err        = (pkt_size == 16'd0) || (pkt_size > MAX_SIZE);
  // ceil(size/2)-1 == floor((size-1)/2); size 0 is caught by hdr_err first
  assign hdr_beats_left = (pkt_size - 16'd1) >> 1;
  assign err_cnt_d      = (err_cnt_q == 16'hffff) ? err_cnt_q : err_cnt_q + 16'd1;
  assign size_err_cnt   = err_cnt_q;

  always_comb begin
    M_AXIS_TLAST = 1'b0;
    M_AXIS_TSTRB = STRB_FULL;
    case (state_q)
      HDR: begin
        if (hdr_err || hdr_beats_left == 16'd0) begin
          M_AXIS_TLAST = 1'b1;
          if (!hdr_err && pkt_size == 16'd1) M_AXIS_TSTRB = STRB_HALF;
        end
      end
      PAYLOAD: begin
        if (beats_left_q == 16'd1) begin
          M_AXIS_TLAST = 1'b1;
          if (odd_q) M_AXIS_TSTRB = STRB_HALF;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= '0;
      beats_left_q <= '0;
      odd_q        <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable && sel_vld) begin
            grant_q <= sel_idx;
            state_q <= HDR;
          end
        end
        HDR: begin
          if (xfer) begin
            if (hdr_err || hdr_beats_left == 16'd0) begin
              if (hdr_err) err_cnt_q <= err_cnt_d;
              last_grant_q <= grant_q;
              state_q      <= IDLE;
            end else begin
              beats_left_q <= hdr_beats_left;
              odd_q        <= pkt_size[0];
              state_q      <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            beats_left_q <= beats_left_q - 16'd1;
            if (beats_left_q == 16'd1) begin
              last_grant_q <= grant_q;
              state_q      <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef VITA49_ARB_STATS_EN
  logic [15:0] pkt_cnt_q [NUM_SRC];

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      for (int i = 0; i < NUM_SRC; i++) pkt_cnt_q[i] <= '0;
    end else if (xfer && M_AXIS_TLAST) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (grant_q == 2'(i)) pkt_cnt_q[i] <= pkt_cnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    pkt_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) pkt_cnt[16*i +: 16] = pkt_cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_vita49_pkt_arbiter.sv
// Directed bench for vita49_pkt_arbiter (NUM_SRC=2): cycle table plus stall and reset sequences.
module tb_vita49_pkt_arbiter;

  logic         clk;
  logic         rst;
  logic [127:0] s_dat;
  logic [1:0]   s_vld;
  logic [1:0]   s_rdy;
  logic [63:0]  m_dat;
  logic         m_vld;
  logic         m_rdy;
  logic         m_last;
  logic [7:0]   m_strb;
  logic [1:0]   m_dest;
  logic         en;
  logic [15:0]  err_cnt;
`ifdef VITA49_ARB_STATS_EN
  logic [31:0]  pkt_cnt;
`endif

  int n_vec;
  int n_miss;

  vita49_pkt_arbiter dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESET   (rst),
    .S_AXIS_TDATA  (s_dat),
    .S_AXIS_TVALID (s_vld),
    .S_AXIS_TREADY (s_rdy),
    .M_AXIS_TDATA  (m_dat),
    .M_AXIS_TVALID (m_vld),
    .M_AXIS_TREADY (m_rdy),
    .M_AXIS_TLAST  (m_last),
    .M_AXIS_TSTRB  (m_strb),
    .M_AXIS_TDEST  (m_dest),
    .enable        (en),
    .size_err_cnt  (err_cnt)
`ifdef VITA49_ARB_STATS_EN
    ,
    .pkt_cnt       (pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [1:0]  vld;
    logic [63:0] d0;
    logic [63:0] d1;
    logic        evld;
    logic        elast;
    logic [7:0]  estrb;
    logic [1:0]  edest;
    logic [63:0] edat;
    logic [1:0]  erdy;
    logic [15:0] eerr;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [63:0] hdr(input logic [31:0] sid, input logic [15:0] sz);
    return {sid, 16'h0000, sz};
  endfunction

  // idle-cycle vector: nothing may be forwarded
  function automatic vec_t vi(input logic e, input logic [1:0] v, input logic [63:0] a,
                              input logic [63:0] b, input logic [15:0] er);
    vec_t t;
    t.en = e; t.vld = v; t.d0 = a; t.d1 = b;
    t.evld = 1'b0; t.elast = 1'b0; t.estrb = 8'hff; t.edest = 2'd0; t.edat = 64'h0;
    t.erdy = 2'b00; t.eerr = er;
    return t;
  endfunction

  // active-beat vector: granted source forwarded
  function automatic vec_t va(input logic e, input logic [1:0] v, input logic [63:0] a,
                              input logic [63:0] b, input logic l, input logic [7:0] st,
                              input logic [1:0] dst, input logic [63:0] dt, input logic [1:0] rd,
                              input logic [15:0] er);
    vec_t t;
    t.en = e; t.vld = v; t.d0 = a; t.d1 = b;
    t.evld = 1'b1; t.elast = l; t.estrb = st; t.edest = dst; t.edat = dt;
    t.erdy = rd; t.eerr = er;
    return t;
  endfunction

  function automatic logic [63:0] stall_beat(input int k);
    return (k == 0) ? hdr(32'hC0, 16'd10) : 64'hE000 + 64'(k);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [63:0] h6, h5, h4a, h4b, h4c, h4d, h0, h2, h1, hb, h8;
    int          k;
    logic        rdy_t;

    n_vec  = 0;
    n_miss = 0;
    h6  = hdr(32'hA0, 16'd6);
    h5  = hdr(32'hA1, 16'd5);
    h4a = hdr(32'hA2, 16'd4);
    h4b = hdr(32'hA3, 16'd4);
    h4c = hdr(32'hA4, 16'd4);
    h4d = hdr(32'hA5, 16'd4);
    h0  = hdr(32'hA6, 16'd0);
    h2  = hdr(32'hA7, 16'd2);
    h1  = hdr(32'hA8, 16'd1);
    hb  = hdr(32'hA9, 16'd4097);
    h8  = hdr(32'hB0, 16'd8);

    // single packets, alternating sources, strobes
    tbl.push_back(vi(1'b1, 2'b00, 64'h0, 64'h0, 16'd0));
    tbl.push_back(vi(1'b1, 2'b01, h6, 64'h0, 16'd0));
    tbl.push_back(va(1'b1, 2'b01, h6, 64'h0, 1'b0, 8'hff, 2'd0, h6, 2'b01, 16'd0));
    tbl.push_back(va(1'b1, 2'b01, 64'hD001, 64'h0, 1'b0, 8'hff, 2'd0, 64'hD001, 2'b01, 16'd0));
    tbl.push_back(va(1'b1, 2'b01, 64'hD002, 64'h0, 1'b1, 8'hff, 2'd0, 64'hD002, 2'b01, 16'd0));
    tbl.push_back(vi(1'b1, 2'b10, 64'h0, h5, 16'd0));
    tbl.push_back(va(1'b1, 2'b10, 64'h0, h5, 1'b0, 8'hff, 2'd1, h5, 2'b10, 16'd0));
    tbl.push_back(va(1'b1, 2'b10, 64'h0, 64'hD011, 1'b0, 8'hff, 2'd1, 64'hD011, 2'b10, 16'd0));
    tbl.push_back(va(1'b1, 2'b10, 64'h0, 64'hD012, 1'b1, 8'h0f, 2'd1, 64'hD012, 2'b10, 16'd0));
    // both sources contending: 0,1,0,1 with a bubble between packets
    tbl.push_back(vi(1'b1, 2'b11, h4a, h4b, 16'd0));
    tbl.push_back(va(1'b1, 2'b11, h4a, h4b, 1'b0, 8'hff, 2'd0, h4a, 2'b01, 16'd0));
    tbl.push_back(va(1'b1, 2'b11, 64'hD021, h4b, 1'b1, 8'hff, 2'd0, 64'hD021, 2'b01, 16'd0));
    tbl.push_back(vi(1'b1, 2'b11, h4c, h4b, 16'd0));
    tbl.push_back(va(1'b1, 2'b11, h4c, h4b, 1'b0, 8'hff, 2'd1, h4b, 2'b10, 16'd0));
    tbl.push_back(va(1'b1, 2'b11, h4c, 64'hD031, 1'b1, 8'hff, 2'd1, 64'hD031, 2'b10, 16'd0));
    tbl.push_back(vi(1'b1, 2'b11, h4c, h4d, 16'd0));
    tbl.push_back(va(1'b1, 2'b11, h4c, h4d, 1'b0, 8'hff, 2'd0, h4c, 2'b01, 16'd0));
    tbl.push_back(va(1'b1, 2'b11, 64'hD022, h4d, 1'b1, 8'hff, 2'd0, 64'hD022, 2'b01, 16'd0));
    tbl.push_back(vi(1'b1, 2'b10, 64'h0, h4d, 16'd0));
    tbl.push_back(va(1'b1, 2'b10, 64'h0, h4d, 1'b0, 8'hff, 2'd1, h4d, 2'b10, 16'd0));
    tbl.push_back(va(1'b1, 2'b10, 64'h0, 64'hD032, 1'b1, 8'hff, 2'd1, 64'hD032, 2'b10, 16'd0));
    // size 0 error, size 2 and size 1 single beats, oversize error
    tbl.push_back(vi(1'b1, 2'b01, h0, 64'h0, 16'd0));
    tbl.push_back(va(1'b1, 2'b01, h0, 64'h0, 1'b1, 8'hff, 2'd0, h0, 2'b01, 16'd0));
    tbl.push_back(vi(1'b1, 2'b01, h2, 64'h0, 16'd1));
    tbl.push_back(va(1'b1, 2'b01, h2, 64'h0, 1'b1, 8'hff, 2'd0, h2, 2'b01, 16'd1));
    tbl.push_back(vi(1'b1, 2'b01, h1, 64'h0, 16'd1));
    tbl.push_back(va(1'b1, 2'b01, h1, 64'h0, 1'b1, 8'h0f, 2'd0, h1, 2'b01, 16'd1));
    tbl.push_back(vi(1'b1, 2'b01, hb, 64'h0, 16'd1));
    tbl.push_back(va(1'b1, 2'b01, hb, 64'h0, 1'b1, 8'hff, 2'd0, hb, 2'b01, 16'd1));
    // enable low blocks grants; dropping it mid-packet lets the packet finish
    tbl.push_back(vi(1'b0, 2'b01, h6, 64'h0, 16'd2));
    tbl.push_back(vi(1'b0, 2'b01, h6, 64'h0, 16'd2));
    tbl.push_back(vi(1'b1, 2'b01, h6, 64'h0, 16'd2));
    tbl.push_back(va(1'b0, 2'b01, h6, 64'h0, 1'b0, 8'hff, 2'd0, h6, 2'b01, 16'd2));
    tbl.push_back(va(1'b0, 2'b01, 64'hD041, 64'h0, 1'b0, 8'hff, 2'd0, 64'hD041, 2'b01, 16'd2));
    tbl.push_back(va(1'b0, 2'b01, 64'hD042, 64'h0, 1'b1, 8'hff, 2'd0, 64'hD042, 2'b01, 16'd2));
    tbl.push_back(vi(1'b0, 2'b01, h2, 64'h0, 16'd2));
    tbl.push_back(vi(1'b0, 2'b01, h2, 64'h0, 16'd2));
    tbl.push_back(vi(1'b1, 2'b01, h2, 64'h0, 16'd2));
    tbl.push_back(va(1'b1, 2'b01, h2, 64'h0, 1'b1, 8'hff, 2'd0, h2, 2'b01, 16'd2));

    rst   = 1'b1;
    en    = 1'b1;
    s_vld = 2'b00;
    s_dat = '0;
    m_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_tvalid", 64'(m_vld), 64'h0);
    check("reset_tready", 64'(s_rdy), 64'h0);
    check("reset_tlast",  64'(m_last), 64'h0);
    check("reset_tstrb",  64'(m_strb), 64'hff);
    check("reset_tdest",  64'(m_dest), 64'h0);
    check("reset_errcnt", 64'(err_cnt), 64'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      en    = tbl[i].en;
      s_vld = tbl[i].vld;
      s_dat = {tbl[i].d1, tbl[i].d0};
      m_rdy = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d_tvalid", i), 64'(m_vld), 64'(tbl[i].evld));
      check($sformatf("v%0d_tready", i), 64'(s_rdy), 64'(tbl[i].erdy));
      check($sformatf("v%0d_errcnt", i), 64'(err_cnt), 64'(tbl[i].eerr));
      if (tbl[i].evld) begin
        check($sformatf("v%0d_tlast", i), 64'(m_last), 64'(tbl[i].elast));
        check($sformatf("v%0d_tstrb", i), 64'(m_strb), 64'(tbl[i].estrb));
        check($sformatf("v%0d_tdest", i), 64'(m_dest), 64'(tbl[i].edest));
        check($sformatf("v%0d_tdata", i), m_dat, tbl[i].edat);
      end
    end

    // 10-word packet under 1/0 TREADY toggling: 5 transfers, data held while stalled
    @(posedge clk);
    #1 s_vld = 2'b00;
    en = 1'b1;
    k = 0;
    rdy_t = 1'b1;
    for (int c = 0; c < 40 && k < 5; c++) begin
      @(posedge clk);
      #1;
      s_vld = 2'b01;
      s_dat = {64'h0, stall_beat(k)};
      m_rdy = rdy_t;
      rdy_t = ~rdy_t;
      @(negedge clk);
      if (m_vld) begin
        check($sformatf("stall_k%0d_tdata", k), m_dat, stall_beat(k));
        check($sformatf("stall_k%0d_tlast", k), 64'(m_last), 64'(k == 4));
        if (m_rdy) begin
          check($sformatf("stall_k%0d_tstrb", k), 64'(m_strb), 64'hff);
          k++;
        end
      end
    end
    check("stall_transfers", 64'(k), 64'd5);
    @(posedge clk);
    #1 s_vld = 2'b00;
    m_rdy = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("stall_after_tvalid", 64'(m_vld), 64'h0);
      @(posedge clk);
    end

    // reset in the middle of a src1 packet
    #1 s_vld = 2'b10;
    s_dat = {h8, 64'h0};
    @(posedge clk);
    @(posedge clk);
    #1 s_dat = {64'hF001, 64'h0};
    @(negedge clk);
    check("rst_pre_tvalid", 64'(m_vld), 64'h1);
    check("rst_pre_tdest", 64'(m_dest), 64'h1);
    check("rst_pre_errcnt", 64'(err_cnt), 64'd2);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_mid_tvalid", 64'(m_vld), 64'h0);
    check("rst_mid_tready", 64'(s_rdy), 64'h0);
    check("rst_mid_errcnt", 64'(err_cnt), 64'h0);
    check("rst_mid_tdest", 64'(m_dest), 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    s_vld = 2'b00;
    @(negedge clk);
    check("rst_after_tvalid", 64'(m_vld), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
